// File: rtl/stage3_divider.sv
`default_nettype none
// ============================================================================
// Module      : stage3_divider
// Description : Multi-cycle RV32M divide/remainder unit for the execute stage.
//               Radix-2 restoring divider, one quotient bit per cycle. Holds
//               the front of the pipeline while iterating, keeps its result
//               through a downstream data-cache stall, and drops everything
//               on a pipeline flush.
// Ports       : clk_i      - clock
//               rst_ni     - asynchronous active-low reset
//               start_i    - divide-class instruction present in execute
//               op_i       - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//               dividend_i - rs1 value
//               divisor_i  - rs2 value
//               stall_i    - downstream stall, result must be held
//               flush_i    - kill the in-flight operation
//               result_o   - registered quotient or remainder
//               valid_o    - result_o valid
//               stall_o    - request IF/ID/EX hold
// Revision    : 1.0 - initial release
// ============================================================================
module stage3_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            stall_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e          state_q;
  logic            rem_sel_q;   // 1: remainder is the result, 0: quotient
  logic            neg_q;       // final result must be negated
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;       // holds the dividend, shifted out as quotient bits come in
  logic [XLEN-1:0] divisor_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;
  logic            valid_q;

  // ---------------------------------------------------------------------------
  // Operand preparation at accept time
  // ---------------------------------------------------------------------------
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            sgn_ovf;
  logic [XLEN-1:0] special_res;

  assign is_signed = ~op_i[0];
  assign a_neg     = is_signed & dividend_i[XLEN-1];
  assign b_neg     = is_signed & divisor_i[XLEN-1];
  assign a_abs     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign b_abs     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
  assign div_zero  = (divisor_i == '0);
  assign sgn_ovf   = is_signed
                   & (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                   & (divisor_i == {XLEN{1'b1}});

  // Divide by zero: quotient all ones, remainder = dividend.
  // Signed overflow: quotient = dividend (most negative value), remainder 0.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op_i[1] ? dividend_i : {XLEN{1'b1}};
    end else begin
      special_res = op_i[1] ? '0 : dividend_i;
    end
  end

  // ---------------------------------------------------------------------------
  // One restoring iteration: single XLEN+1 bit subtractor
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   trial;
  logic            trial_ok;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;
  logic [XLEN-1:0] raw_res;
  logic [XLEN-1:0] final_res;

  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign trial     = rem_shift - {1'b0, divisor_q};
  // Partial remainder is always below the divisor, so the shifted value is
  // below twice the divisor and the top bit of the trial is a clean sign.
  assign trial_ok  = ~trial[XLEN];
  assign rem_d     = trial_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_d     = {quo_q[XLEN-2:0], trial_ok};
  assign raw_res   = rem_sel_q ? rem_d : quo_d;
  assign final_res = neg_q ? (~raw_res + 1'b1) : raw_res;

  // ---------------------------------------------------------------------------
  // Control FSM with registered result/valid
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      rem_sel_q <= 1'b0;
      neg_q     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rem_sel_q <= op_i[1];
            // Remainder takes the dividend's sign; quotient is negative when signs differ.
            neg_q     <= op_i[1] ? a_neg : (a_neg ^ b_neg);
            if (div_zero || sgn_ovf) begin
              result_q <= special_res;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              rem_q     <= '0;
              quo_q     <= a_abs;
              divisor_q <= b_abs;
              cnt_q     <= '0;
              state_q   <= S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            result_q <= final_res;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          if (!stall_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign valid_o  = valid_q;
  assign stall_o  = ((state_q == S_IDLE) && start_i && !flush_i) || (state_q == S_DIVIDE);

endmodule
`default_nettype wire

// File: tb/tb_stage3_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage3_divider
// Description : Self-checking bench for stage3_divider. Directed cases plus
//               randomized operations compared to an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage3_divider;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        valid_o;
  logic        stall_o;

  int n_total = 0;
  int n_pass  = 0;

  stage3_divider #(.XLEN(32)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .result_o   (result_o),
    .valid_o    (valid_o),
    .stall_o    (stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // RISC-V M-extension semantics computed with wide signed arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0: t = 64'(sa / sb);
      2'd1: t = {32'd0, a / b};
      2'd2: t = 64'(sa % sb);
      default: t = {32'd0, a % b};
    endcase
    return t[31:0];
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issue one operation, measure latency and stall cycles, check result, then
  // optionally hold the result with stall_i for 'hold' cycles.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input logic [31:0] exp);
    int lat;
    int cyc;
    int scnt;
    lat = is_special(op, a, b) ? 1 : 33;
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b;
    #1;
    check("stall_accept", {31'd0, stall_o}, 32'd1);
    scnt = 1;
    cyc  = 1;
    @(negedge clk_i);
    start_i = 1'b0;
    while (!valid_o && cyc < 40) begin
      if (stall_o) scnt++;
      @(negedge clk_i);
      cyc++;
    end
    check("latency", cyc, lat);
    if (!valid_o) return;
    check("stall_cycles", scnt, lat);
    check("stall_done", {31'd0, stall_o}, 32'd0);
    check("result", result_o, exp);
    if (hold > 0) begin
      stall_i = 1'b1;
      for (int i = 1; i <= hold; i++) begin
        @(negedge clk_i);
        if (i == hold) stall_i = 1'b0;
        check("hold_valid", {31'd0, valid_o}, 32'd1);
        check("hold_result", result_o, exp);
      end
    end
    @(negedge clk_i);
    check("back_idle", {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          seen;

    rst_ni = 1'b0; start_i = 1'b0; op_i = 2'd0; dividend_i = '0; divisor_i = '0;
    stall_i = 1'b0; flush_i = 1'b0;
    #1;
    check("rst_result", result_o, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed cases
    run_op(2'd1, 32'd100, 32'd7, 0, 32'd14);
    run_op(2'd3, 32'd100, 32'd7, 0, 32'd2);
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF);
    run_op(2'd0, 32'd7, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFD);
    run_op(2'd1, 32'd5, 32'd0, 0, 32'hFFFF_FFFF);
    run_op(2'd2, 32'h8000_0000, 32'd0, 0, 32'h8000_0000);
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'd1, 5, 32'hFFFF_FFFF);
    run_op(2'd1, 32'd0, 32'd9, 0, 32'd0);

    // Flush while idle suppresses acceptance
    @(negedge clk_i);
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'd1; dividend_i = 32'd50; divisor_i = 32'd5;
    #1;
    check("flush_idle_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_idle_state", {31'd0, stall_o | valid_o}, 32'd0);

    // Flush at iteration 10
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'd1; dividend_i = 32'd100; divisor_i = 32'd7;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_valid", {31'd0, valid_o}, 32'd0);
    check("flush_stall", {31'd0, stall_o}, 32'd0);
    seen = 0;
    repeat (35) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    check("flush_no_valid", seen, 0);
    run_op(2'd1, 32'd9, 32'd3, 0, 32'd3);

    // Asynchronous reset mid-divide (previous result is nonzero)
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'd1; dividend_i = 32'd100; divisor_i = 32'd7;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_result", result_o, 32'd0);
    check("arst_valid", {31'd0, valid_o}, 32'd0);
    check("arst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_op(2'd3, 32'd1000, 32'd33, 0, 32'd10);

    // Randomized operations against the reference model
    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'd0;
        4: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      run_op(rop, ra, rb, $urandom_range(0, 2), model(rop, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
